// File: rtl/regex_stream_feeder.sv
// rtl/regex_stream_feeder.sv - parallel-to-serial front end for the regex matcher
// Shifts each accepted word MSB-first into the matcher and reports line-tagged match pulses.
module regex_stream_feeder #(
  parameter int WIDTH  = 21,
  parameter int LINE_W = 14
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              word_valid,
  input  logic [WIDTH-1:0]  word_data,
  output logic              word_ready,
  output logic              rx_i,
  output logic              rx_ic,
  input  logic              rx_o,
  output logic              match_valid,
  output logic [LINE_W-1:0] match_line,
  output logic              word_done,
  output logic              busy
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GAP    = 2'd1,
    SHIFT  = 2'd2,
    SAMPLE = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  shreg_q, shreg_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [LINE_W-1:0] line_cnt_q, line_cnt_d;
  logic              rx_i_q;
  logic              rx_ic_q, rx_ic_d;
  logic              match_valid_q, match_valid_d;
  logic [LINE_W-1:0] match_line_q, match_line_d;
  logic              word_done_q, word_done_d;
  logic              busy_q, busy_d;

  // Gating with rx_i_q keeps ready low during reset and until the first edge after release.
  assign word_ready  = (state_q == IDLE) && rx_i_q;
  assign rx_i        = rx_i_q;
  assign rx_ic       = rx_ic_q;
  assign match_valid = match_valid_q;
  assign match_line  = match_line_q;
  assign word_done   = word_done_q;
  assign busy        = busy_q;

  always_comb begin
    state_d       = state_q;
    shreg_d       = shreg_q;
    bit_cnt_d     = bit_cnt_q;
    line_cnt_d    = line_cnt_q;
    rx_ic_d       = 1'b0;
    match_valid_d = 1'b0;
    match_line_d  = match_line_q;
    word_done_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (word_valid && word_ready) begin
          shreg_d    = word_data;
          line_cnt_d = line_cnt_q + LINE_W'(1);
          bit_cnt_d  = CNT_W'(WIDTH - 1);
          state_d    = GAP;
        end
      end
      GAP: begin
        // rx_ic is registered, so the MSB is launched here to appear in the first SHIFT cycle.
        rx_ic_d = shreg_q[WIDTH-1];
        shreg_d = shreg_q << 1;
        state_d = SHIFT;
      end
      SHIFT: begin
        if (bit_cnt_q == '0) begin
          state_d = SAMPLE;
        end else begin
          rx_ic_d   = shreg_q[WIDTH-1];
          shreg_d   = shreg_q << 1;
          bit_cnt_d = bit_cnt_q - CNT_W'(1);
        end
      end
      SAMPLE: begin
        match_valid_d = rx_o;
        match_line_d  = line_cnt_q;
        word_done_d   = 1'b1;
        state_d       = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      shreg_q       <= '0;
      bit_cnt_q     <= '0;
      line_cnt_q    <= '0;
      rx_i_q        <= 1'b0;
      rx_ic_q       <= 1'b0;
      match_valid_q <= 1'b0;
      match_line_q  <= '0;
      word_done_q   <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      shreg_q       <= shreg_d;
      bit_cnt_q     <= bit_cnt_d;
      line_cnt_q    <= line_cnt_d;
      rx_i_q        <= 1'b1;
      rx_ic_q       <= rx_ic_d;
      match_valid_q <= match_valid_d;
      match_line_q  <= match_line_d;
      word_done_q   <= word_done_d;
      busy_q        <= busy_d;
    end
  end

endmodule

// File: tb/tb_regex_stream_feeder.sv
// tb/tb_regex_stream_feeder.sv - directed scoreboard bench for regex_stream_feeder
// A second instance with LINE_W=2 and rx_o tied high follows the same stimulus to show line wrap.
module tb_regex_stream_feeder;

  logic        clk;
  logic        reset;
  logic        word_valid;
  logic [20:0] word_data;
  logic        rx_o;
  logic        rx_o2;

  logic        word_ready, rx_i, rx_ic, match_valid, word_done, busy;
  logic [13:0] match_line;
  logic        word_ready2, rx_i2, rx_ic2, match_valid2, word_done2, busy2;
  logic [1:0]  match_line2;

  regex_stream_feeder #(.WIDTH(21), .LINE_W(14)) dut (
    .clk(clk), .reset(reset), .word_valid(word_valid), .word_data(word_data),
    .word_ready(word_ready), .rx_i(rx_i), .rx_ic(rx_ic), .rx_o(rx_o),
    .match_valid(match_valid), .match_line(match_line), .word_done(word_done), .busy(busy)
  );

  regex_stream_feeder #(.WIDTH(21), .LINE_W(2)) dut2 (
    .clk(clk), .reset(reset), .word_valid(word_valid), .word_data(word_data),
    .word_ready(word_ready2), .rx_i(rx_i2), .rx_ic(rx_ic2), .rx_o(rx_o2),
    .match_valid(match_valid2), .match_line(match_line2), .word_done(word_done2), .busy(busy2)
  );

  typedef struct {
    logic [13:0] line;
    logic        hit;
  } exp_t;

  exp_t        sb[$];
  logic [13:0] exp_line;
  int          total;
  int          bad;
  int          cyc;
  int          last_acc;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one word, follow it bit by bit, and score the result against the queue.
  task automatic send(input logic [20:0] d, input logic rxo, input bit keep, input bit chk_gap);
    int   n;
    exp_t e;
    word_data  = d;
    word_valid = 1'b1;
    n = 0;
    while (word_ready !== 1'b1 && n < 60) begin
      tick;
      n++;
    end
    if (word_ready !== 1'b1) chk("ready_timeout", {31'd0, word_ready}, 32'd1);
    tick;
    if (chk_gap) chk("accept_gap", cyc - last_acc, 32'd24);
    last_acc = cyc;
    exp_line = exp_line + 14'd1;
    e.line = exp_line;
    e.hit  = rxo;
    sb.push_back(e);
    if (!keep) word_valid = 1'b0;
    word_data = 21'($urandom);
    chk("gap_rx_ic", {31'd0, rx_ic}, 32'd0);
    chk("gap_busy", {31'd0, busy}, 32'd1);
    chk("gap_ready", {31'd0, word_ready}, 32'd0);
    chk("gap_done", {31'd0, word_done}, 32'd0);
    tick;
    for (int k = 0; k < 21; k++) begin
      chk("rx_ic_bit", {31'd0, rx_ic}, {31'd0, d[20-k]});
      tick;
    end
    chk("sample_rx_ic", {31'd0, rx_ic}, 32'd0);
    chk("sample_busy", {31'd0, busy}, 32'd1);
    rx_o = rxo;
    tick;
    rx_o = 1'b0;
    chk("word_done", {31'd0, word_done}, 32'd1);
    chk("done_busy", {31'd0, busy}, 32'd0);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("match_valid", {31'd0, match_valid}, {31'd0, e.hit});
      if (e.hit) chk("match_line", {18'd0, match_line}, {18'd0, e.line});
      chk("word_done2", {31'd0, word_done2}, 32'd1);
      chk("match_valid2", {31'd0, match_valid2}, 32'd1);
      chk("match_line2", {30'd0, match_line2}, {30'd0, e.line[1:0]});
    end else begin
      chk("sb_underflow", sb.size(), 32'd1);
    end
  endtask

  initial begin
    logic [20:0] d5;
    total = 0; bad = 0; cyc = 0; last_acc = 0; exp_line = 14'd0;
    word_valid = 1'b0; word_data = 21'd0; rx_o = 1'b0; rx_o2 = 1'b1;
    reset = 1'b1;
    #1 reset = 1'b0;

    for (int i = 0; i < 3; i++) begin
      tick;
      chk("rst_ready", {31'd0, word_ready}, 32'd0);
      chk("rst_rx_i", {31'd0, rx_i}, 32'd0);
      chk("rst_rx_ic", {31'd0, rx_ic}, 32'd0);
      chk("rst_match_valid", {31'd0, match_valid}, 32'd0);
      chk("rst_match_line", {18'd0, match_line}, 32'd0);
      chk("rst_word_done", {31'd0, word_done}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
    end
    reset = 1'b1;
    tick;
    chk("rel_rx_i", {31'd0, rx_i}, 32'd1);
    chk("rel_ready", {31'd0, word_ready}, 32'd1);

    send(21'h155555, 1'b0, 1'b0, 1'b0);
    tick;
    chk("single_pulse", {31'd0, word_done}, 32'd0);
    chk("rx_i_held", {31'd0, rx_i}, 32'd1);

    reset = 1'b0;
    tick;
    reset = 1'b1;
    tick;
    exp_line = 14'd0;
    sb.delete();

    send(21'h0F0F0F, 1'b0, 1'b1, 1'b0);
    send(21'h1ABCDE, 1'b1, 1'b1, 1'b1);
    send(21'h000001, 1'b0, 1'b0, 1'b1);
    tick;
    chk("b2b_last_pulse", {31'd0, word_done}, 32'd0);
    chk("b2b_no_match", {31'd0, match_valid}, 32'd0);

    send(21'($urandom), 1'b0, 1'b0, 1'b0);

    d5 = 21'h12D3A7;
    word_data = d5;
    word_valid = 1'b1;
    tick;
    word_valid = 1'b0;
    chk("w5_gap_busy", {31'd0, busy}, 32'd1);
    tick;
    for (int k = 0; k < 10; k++) tick;
    chk("w5_bit10", {31'd0, rx_ic}, {31'd0, d5[10]});
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_rx_ic", {31'd0, rx_ic}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_ready", {31'd0, word_ready}, 32'd0);
    chk("mid_rst_rx_i", {31'd0, rx_i}, 32'd0);
    exp_line = 14'd0;
    for (int i = 0; i < 2; i++) begin
      tick;
      chk("mid_rst_done", {31'd0, word_done}, 32'd0);
      chk("mid_rst_match", {31'd0, match_valid}, 32'd0);
    end
    reset = 1'b1;
    tick;
    chk("rel2_ready", {31'd0, word_ready}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("post_rst_done", {31'd0, word_done}, 32'd0);
    end

    send(21'h1FFFFF, 1'b1, 1'b0, 1'b0);
    send(21'h000000, 1'b0, 1'b0, 1'b0);
    send(21'($urandom), 1'b1, 1'b0, 1'b0);
    send(21'($urandom), 1'b1, 1'b0, 1'b0);
    send(21'h0AAAAA, 1'b1, 1'b0, 1'b0);
    tick;
    chk("end_idle_busy", {31'd0, busy}, 32'd0);
    chk("sb_empty", sb.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
